// File: rtl/riscv_dram_line_ctrl_if.sv
// Miss-request and DRAM-array port bundle for the line controller.
// slave is the controller's view; master is the miss logic plus the array.
interface riscv_dram_line_ctrl_if #(
  parameter int DATA_WIDTH = 128,
  parameter int S_ADDR     = 10
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wb;
  logic                  req_fill;
  logic [S_ADDR-1:0]     req_wb_addr;
  logic [DATA_WIDTH-1:0] req_wb_data;
  logic [S_ADDR-1:0]     req_fill_addr;
  logic                  done;
  logic                  fill_valid;
  logic [DATA_WIDTH-1:0] fill_data;
  logic                  mem_wren;
  logic                  mem_rden;
  logic [S_ADDR-1:0]     mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_wb, req_fill, req_wb_addr, req_wb_data, req_fill_addr, mem_rdata,
    output req_ready, done, fill_valid, fill_data, mem_wren, mem_rden, mem_addr, mem_wdata
  );
  modport master (
    output req_valid, req_wb, req_fill, req_wb_addr, req_wb_data, req_fill_addr, mem_rdata,
    input  req_ready, done, fill_valid, fill_data, mem_wren, mem_rden, mem_addr, mem_wdata
  );
endinterface

// File: rtl/riscv_dram_line_ctrl.sv
// Line-wide DRAM initiator: optional victim writeback, then optional refill, one
// transaction at a time. Every output is a register loaded alongside the state.
module riscv_dram_line_ctrl #(
  parameter int DATA_WIDTH = 128,
  parameter int S_ADDR     = 10,
  parameter int RD_LAT     = 1
) (
  input  logic clk,
  input  logic rst,
  riscv_dram_line_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT, DONE} state_e;

  localparam logic [2:0] LAT = 3'(RD_LAT);

  state_e                state_q;
  logic                  fill_q;
  logic [S_ADDR-1:0]     fill_addr_q;
  logic [2:0]            lat_cnt_q;
  logic                  ready_q, done_q, fill_valid_q, wren_q, rden_q;
  logic [S_ADDR-1:0]     addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, fill_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      fill_q       <= 1'b0;
      fill_addr_q  <= '0;
      lat_cnt_q    <= '0;
      ready_q      <= 1'b1;
      done_q       <= 1'b0;
      fill_valid_q <= 1'b0;
      wren_q       <= 1'b0;
      rden_q       <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      fill_data_q  <= '0;
    end else begin
      // Strobes and write data default low; each state re-asserts what it needs.
      done_q       <= 1'b0;
      fill_valid_q <= 1'b0;
      wren_q       <= 1'b0;
      rden_q       <= 1'b0;
      wdata_q      <= '0;
      case (state_q)
        IDLE: if (bus.req_valid && ready_q) begin
          ready_q     <= 1'b0;
          fill_q      <= bus.req_fill;
          fill_addr_q <= bus.req_fill_addr;
          if (bus.req_wb) begin
            state_q <= WRITE;
            wren_q  <= 1'b1;
            addr_q  <= bus.req_wb_addr;
            wdata_q <= bus.req_wb_data;
          end else if (bus.req_fill) begin
            state_q <= READ;
            rden_q  <= 1'b1;
            addr_q  <= bus.req_fill_addr;
          end else begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        WRITE: if (fill_q) begin
          state_q <= READ;
          rden_q  <= 1'b1;
          addr_q  <= fill_addr_q;
        end else begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        READ: begin
          state_q   <= WAIT;
          lat_cnt_q <= 3'd1;
        end
        // addr_q stays on the fill line; the array re-reads it every cycle.
        WAIT: if (lat_cnt_q == LAT) begin
          state_q      <= DONE;
          fill_data_q  <= bus.mem_rdata;
          done_q       <= 1'b1;
          fill_valid_q <= fill_q;
        end else begin
          lat_cnt_q <= lat_cnt_q + 3'd1;
        end
        DONE: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.done       = done_q;
  assign bus.fill_valid = fill_valid_q;
  assign bus.fill_data  = fill_data_q;
  assign bus.mem_wren   = wren_q;
  assign bus.mem_rden   = rden_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
endmodule

// File: tb/tb_riscv_dram_line_ctrl.sv
// Directed bench: controller A (RD_LAT=1) and B (RD_LAT=3), each with a registered DRAM array model.
module tb_riscv_dram_line_ctrl;
  localparam int DW = 128;
  localparam int AW = 10;
  localparam int LAT_A = 1;
  localparam int LAT_B = 3;

  localparam logic [DW-1:0] V5   = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [DW-1:0] VA5  = {16{8'hA5}};
  localparam logic [DW-1:0] VDE  = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
  localparam logic [DW-1:0] VOLD = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
  localparam logic [DW-1:0] VNEW = 128'hFEDC_BA98_7654_3210_FEDC_BA98_7654_3210;
  localparam logic [DW-1:0] VWB  = 128'h5A5A5A5A_00000000_5A5A5A5A_00000000;
  localparam logic [DW-1:0] V1   = {4{32'h1111_1111}};
  localparam logic [DW-1:0] V2   = {4{32'h2222_2222}};
  localparam logic [DW-1:0] V3   = {4{32'h3333_3333}};

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  riscv_dram_line_ctrl_if #(.DATA_WIDTH(DW), .S_ADDR(AW)) ia ();
  riscv_dram_line_ctrl_if #(.DATA_WIDTH(DW), .S_ADDR(AW)) ib ();

  riscv_dram_line_ctrl #(.DATA_WIDTH(DW), .S_ADDR(AW), .RD_LAT(LAT_A)) u_a (.clk(clk), .rst(rst_a), .bus(ia.slave));
  riscv_dram_line_ctrl #(.DATA_WIDTH(DW), .S_ADDR(AW), .RD_LAT(LAT_B)) u_b (.clk(clk), .rst(rst_b), .bus(ib.slave));

  // Array models: a preload port shared by both, write ignored when rden is also set.
  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;
  logic [DW-1:0] mem_a [1024];
  logic [DW-1:0] mem_b [1024];
  logic [DW-1:0] pipe_a [LAT_A];
  logic [DW-1:0] pipe_b [LAT_B];

  always @(posedge clk) begin
    pipe_a[0] <= mem_a[ia.mem_addr];
    for (int k = 1; k < LAT_A; k++) pipe_a[k] <= pipe_a[k-1];
    if (pre_we) mem_a[pre_addr] <= pre_data;
    else if (ia.mem_wren && !ia.mem_rden) mem_a[ia.mem_addr] <= ia.mem_wdata;
  end
  always @(posedge clk) begin
    pipe_b[0] <= mem_b[ib.mem_addr];
    for (int k = 1; k < LAT_B; k++) pipe_b[k] <= pipe_b[k-1];
    if (pre_we) mem_b[pre_addr] <= pre_data;
    else if (ib.mem_wren && !ib.mem_rden) mem_b[ib.mem_addr] <= ib.mem_wdata;
  end
  assign ia.mem_rdata = pipe_a[LAT_A-1];
  assign ib.mem_rdata = pipe_b[LAT_B-1];

  // Continuous protocol monitor on both controllers.
  int ovl_err = 0;
  int wd_err  = 0;
  always @(negedge clk) begin
    if (ia.mem_wren && ia.mem_rden) ovl_err++;
    if (ib.mem_wren && ib.mem_rden) ovl_err++;
    if (!ia.mem_wren && ia.mem_wdata != '0) wd_err++;
    if (!ib.mem_wren && ib.mem_wdata != '0) wd_err++;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    step();
    pre_we = 1'b0;
  endtask

  // One transaction on A; reports done cycle (-1 on timeout), fill_valid, and DRAM activity.
  task automatic run_a(input logic wb, input logic fill, input logic [AW-1:0] wba,
                       input logic [DW-1:0] wbd, input logic [AW-1:0] fa,
                       output int lat, output logic fv, output int nrd, output int nwr,
                       output logic [AW-1:0] rda, output logic [AW-1:0] wra);
    lat = -1; fv = 1'b0; nrd = 0; nwr = 0; rda = '0; wra = '0;
    for (int i = 0; i < 20 && !ia.req_ready; i++) step();
    ia.req_valid = 1'b1; ia.req_wb = wb; ia.req_fill = fill;
    ia.req_wb_addr = wba; ia.req_wb_data = wbd; ia.req_fill_addr = fa;
    step();
    // Fields are registered at accept; scramble them to prove it.
    ia.req_valid = 1'b0; ia.req_wb = 1'($urandom); ia.req_fill = 1'($urandom);
    ia.req_wb_addr = AW'($urandom); ia.req_fill_addr = AW'($urandom);
    ia.req_wb_data = {4{$urandom}};
    for (int c = 1; c <= 20; c++) begin
      if (ia.mem_rden) begin nrd++; rda = ia.mem_addr; end
      if (ia.mem_wren) begin nwr++; wra = ia.mem_addr; end
      if (ia.done) begin lat = c; fv = ia.fill_valid; break; end
      step();
    end
  endtask

  int lat, nrd, nwr;
  logic fv;
  logic [AW-1:0] rda, wra;
  int acc [4];
  int dn  [4];
  logic [DW-1:0] fd [4];
  int nacc, ndone;

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    ia.req_valid = 1'b0; ia.req_wb = 1'b0; ia.req_fill = 1'b0;
    ia.req_wb_addr = '0; ia.req_wb_data = '0; ia.req_fill_addr = '0;
    ib.req_valid = 1'b0; ib.req_wb = 1'b0; ib.req_fill = 1'b0;
    ib.req_wb_addr = '0; ib.req_wb_data = '0; ib.req_fill_addr = '0;
    repeat (3) step();
    chk("rst_ready", ia.req_ready, 1);
    chk("rst_done", ia.done, 0);
    chk("rst_fv", ia.fill_valid, 0);
    chk("rst_wren", ia.mem_wren, 0);
    chk("rst_rden", ia.mem_rden, 0);
    chk("rst_addr", ia.mem_addr, 0);
    chk("rst_wdata", ia.mem_wdata, 0);
    chk("rst_fdata", ia.fill_data, 0);
    rst_a = 1'b0; rst_b = 1'b0;

    preload(10'h005, V5);
    preload(10'h0AA, VOLD);
    preload(10'h001, V1);
    preload(10'h002, V2);
    preload(10'h003, V3);

    // Fill only
    run_a(0, 1, '0, '0, 10'h005, lat, fv, nrd, nwr, rda, wra);
    chk("fill_lat", lat, 3);
    chk("fill_fv", fv, 1);
    chk("fill_nrd", nrd, 1);
    chk("fill_rdaddr", rda, 10'h005);
    chk("fill_data", ia.fill_data, V5);

    // Writeback + fill
    run_a(1, 1, 10'h3FF, VA5, 10'h001, lat, fv, nrd, nwr, rda, wra);
    chk("wbf_lat", lat, 4);
    chk("wbf_nwr", nwr, 1);
    chk("wbf_wraddr", wra, 10'h3FF);
    chk("wbf_mem3ff", mem_a[10'h3FF], VA5);
    chk("wbf_data", ia.fill_data, V1);
    run_a(0, 1, '0, '0, 10'h3FF, lat, fv, nrd, nwr, rda, wra);
    chk("refill3ff", ia.fill_data, VA5);

    // Same-address writeback then refill
    run_a(1, 1, 10'h010, VDE, 10'h010, lat, fv, nrd, nwr, rda, wra);
    chk("same_lat", lat, 4);
    chk("same_data", ia.fill_data, VDE);

    // Writeback only
    run_a(1, 0, 10'h020, VWB, '0, lat, fv, nrd, nwr, rda, wra);
    chk("wb_lat", lat, 2);
    chk("wb_fv", fv, 0);
    chk("wb_fdata_kept", ia.fill_data, VDE);
    chk("wb_nrd", nrd, 0);
    chk("wb_mem", mem_a[10'h020], VWB);

    // Neither
    run_a(0, 0, '0, '0, '0, lat, fv, nrd, nwr, rda, wra);
    chk("none_lat", lat, 1);
    chk("none_fv", fv, 0);
    step();
    chk("ready_after_done", ia.req_ready, 1);

    // Reset in WAIT
    ia.req_valid = 1'b1; ia.req_wb = 1'b0; ia.req_fill = 1'b1; ia.req_fill_addr = 10'h005;
    step();
    ia.req_valid = 1'b0;
    step();
    rst_a = 1'b1;
    #1;
    chk("rstw_ready", ia.req_ready, 1);
    chk("rstw_rden", ia.mem_rden, 0);
    chk("rstw_wren", ia.mem_wren, 0);
    chk("rstw_done", ia.done, 0);
    step();
    rst_a = 1'b0;

    // Reset in WRITE must suppress the write
    ia.req_valid = 1'b1; ia.req_wb = 1'b1; ia.req_fill = 1'b0;
    ia.req_wb_addr = 10'h0AA; ia.req_wb_data = VNEW;
    step();
    ia.req_valid = 1'b0;
    chk("rstwr_pre_wren", ia.mem_wren, 1);
    rst_a = 1'b1;
    #1;
    chk("rstwr_wren", ia.mem_wren, 0);
    step();
    rst_a = 1'b0;
    step();
    chk("rstwr_mem", mem_a[10'h0AA], VOLD);

    run_a(0, 1, '0, '0, 10'h005, lat, fv, nrd, nwr, rda, wra);
    chk("post_rst_lat", lat, 3);
    chk("post_rst_data", ia.fill_data, V5);

    // B: RD_LAT=3, three back-to-back fills with req_valid held high
    nacc = 0; ndone = 0;
    for (int i = 0; i < 4; i++) begin acc[i] = -1; dn[i] = -1; fd[i] = '0; end
    ib.req_valid = 1'b1; ib.req_wb = 1'b0; ib.req_fill = 1'b1; ib.req_fill_addr = 10'h001;
    for (int c = 0; c < 24; c++) begin
      if (ib.done && ndone < 4) begin dn[ndone] = c; fd[ndone] = ib.fill_data; ndone++; end
      if (ib.req_valid && ib.req_ready && nacc < 4) begin acc[nacc] = c; nacc++; end
      step();
      if (nacc >= 3) ib.req_valid = 1'b0;
      else ib.req_fill_addr = AW'(nacc + 1);
    end
    chk("b_nacc", nacc, 3);
    chk("b_ndone", ndone, 3);
    chk("b_acc1", acc[1], 6);
    chk("b_acc2", acc[2], 12);
    chk("b_done0", dn[0], 5);
    chk("b_done1", dn[1], 11);
    chk("b_done2", dn[2], 17);
    chk("b_data0", fd[0], V1);
    chk("b_data1", fd[1], V2);
    chk("b_data2", fd[2], V3);

    chk("no_wr_rd_overlap", ovl_err, 0);
    chk("wdata_zero_outside_write", wd_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
